// File: rtl/lp805x_ntpin_cond.sv
// lp805x new-timer count-pin conditioner.
// Synchronises the raw pad, filters glitches with a programmable
// persistence counter, applies polarity and reports qualified edges
// through a strobe, a sticky flag and a 6-bit event counter exposed on
// the SFR bus.
module lp805x_ntpin_cond #(
  parameter logic [7:0] CTRL_RSTVAL = 8'h00,
  parameter logic [7:0] NTPCTR_ADDR = 8'he9,
  parameter logic [7:0] NTPST_ADDR  = 8'hed
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic       wr_bit,
  input  logic       rd,
  input  logic       rd_bit,
  input  logic [7:0] wr_addr,
  input  logic [7:0] rd_addr,
  input  logic [7:0] data_in,
  input  logic       bit_in,
  output tri   [7:0] data_out,
  output tri         bit_out,
  input  logic       pin_in,
  output logic       pin_cnt_out,
  output logic       ev_pulse,
  output logic       ev_flag
);

  // Filter counter increment that holds at all-ones instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

  logic [7:0] ctrl;
  logic [3:0] filt_len;
  logic [1:0] edge_sel;
  logic       invert;
  logic       enable;

  logic       s1;
  logic       s2;
  logic       filt;
  logic       filt_d;
  logic [3:0] fcnt;

  logic [5:0] ev_cnt;
  logic       lvl;
  logic       trans;
  logic       dir_match;
  logic       qual;

  logic       wr_ctrl;
  logic       wr_st;
  logic       rd_sel;
  logic [7:0] rd_data;
  logic [7:0] st_val;
  logic       unused_sigs;

  assign filt_len = ctrl[7:4];
  assign edge_sel = ctrl[3:2];
  assign invert   = ctrl[1];
  assign enable   = ctrl[0];

  // Byte writes only; bit-addressed writes never touch these registers.
  assign wr_ctrl = wr & ~wr_bit & (wr_addr == NTPCTR_ADDR);
  assign wr_st   = wr & ~wr_bit & (wr_addr == NTPST_ADDR);

  assign unused_sigs = &{1'b0, rd, rd_bit, bit_in};

  // Control register load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctrl <= CTRL_RSTVAL;
    else if (wr_ctrl) ctrl <= data_in;
  end

  // Two-flop synchroniser on the asynchronous pad.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin_in;
      s2 <= s1;
    end
  end

  // Persistence filter: a new level must be seen filt_len+1 cycles running;
  // when disabled the filter simply follows the synchronised pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt   <= 1'b0;
      filt_d <= 1'b0;
      fcnt   <= 4'd0;
    end else begin
      filt_d <= filt;
      if (!enable) begin
        filt <= s2;
        fcnt <= 4'd0;
      end else if (s2 == filt) begin
        fcnt <= 4'd0;
      end else if (fcnt >= filt_len) begin
        filt <= s2;
        fcnt <= 4'd0;
      end else begin
        fcnt <= sat_inc(fcnt);
      end
    end
  end

  // Level, transition and edge qualification. Direction is read from the
  // post-polarity level so an invert toggle alone (filt static) is silent.
  always_comb begin
    lvl   = filt ^ invert;
    trans = filt ^ filt_d;
    case (edge_sel)
      2'b00:   dir_match = ~lvl;
      2'b01:   dir_match = lvl;
      2'b10:   dir_match = 1'b1;
      default: dir_match = 1'b0;
    endcase
    qual        = enable & trans & dir_match;
    ev_pulse    = qual;
    pin_cnt_out = enable & lvl;
    st_val      = {ev_cnt, lvl, ev_flag};
  end

  // Sticky flag and event counter; a coincident edge overrides a status
  // write, leaving the flag set and the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_flag <= 1'b0;
      ev_cnt  <= 6'd0;
    end else if (qual) begin
      ev_flag <= 1'b1;
      ev_cnt  <= wr_st ? 6'd1 : ev_cnt + 6'd1;
    end else if (wr_st) begin
      ev_flag <= data_in[0];
      ev_cnt  <= 6'd0;
    end
  end

  // Registered read port; sampling before the write lands returns the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sel  <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      rd_sel  <= (rd_addr == NTPCTR_ADDR) | (rd_addr == NTPST_ADDR);
      rd_data <= (rd_addr == NTPCTR_ADDR) ? ctrl : st_val;
    end
  end

  assign data_out = rd_sel ? rd_data : 8'hzz;
  assign bit_out  = 1'bz;

endmodule
